// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter; the address limit and
// fault helper are also meant for the memory-stage exception logic.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_EXT_ACC  = 2'd1,
    S_EXT_RESP = 2'd2
  } dmem_arb_state_t;

  localparam logic [31:0] DMEM_ADDR_LIMIT = 32'd1023;

  function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] limit);
    return addr > limit;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, EXT and data_memory signals of the arbiter; slave is the arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_fault;
  logic              ext_req;
  logic              ext_we;
  logic [31:0]       ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_rdata;
  logic              ext_fault;
  logic [ADDR_W-1:0] mem_byte_address;
  logic              mem_write_enable;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, mem_read_data,
    output cpu_rdata, cpu_stall, cpu_fault,
    output ext_gnt, ext_rvalid, ext_rdata, ext_fault,
    output mem_byte_address, mem_write_enable, mem_write_data
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, mem_read_data,
    input  cpu_rdata, cpu_stall, cpu_fault,
    input  ext_gnt, ext_rvalid, ext_rdata, ext_fault,
    input  mem_byte_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating count of cycles the EXT port has waited behind a busy CPU.
module dmem_starve_counter #(
  parameter int MAX_WAIT = 8,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  assign sat = (cnt == CW'(MAX_WAIT));

  // Clear wins over increment so the forced grant cycle leaves the count at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, EXT is served in idle CPU
// cycles or forced in after MAX_WAIT busy cycles; out-of-range writes are blocked.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] ADDR_LIMIT = DMEM_ADDR_LIMIT,
  parameter int          MAX_WAIT   = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int         CW          = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] ST_CPU      = S_CPU;
  localparam logic [1:0] ST_EXT_ACC  = S_EXT_ACC;
  localparam logic [1:0] ST_EXT_RESP = S_EXT_RESP;

  logic [1:0]    state, state_nxt;
  logic          cpu_active, ext_bad, fault_q;
  logic          wait_sat, cnt_clr, cnt_inc;
  logic [CW-1:0] wait_cnt;

  assign cpu_active    = bus.cpu_mem_read | bus.cpu_mem_write;
  assign bus.cpu_fault = cpu_active & addr_fault(bus.cpu_addr, ADDR_LIMIT);
  assign ext_bad       = addr_fault(bus.ext_addr, ADDR_LIMIT);
  assign bus.cpu_rdata = bus.mem_read_data;

  always_comb begin
    state_nxt            = state;
    bus.mem_byte_address = bus.cpu_addr[ADDR_W-1:0];
    bus.mem_write_data   = bus.cpu_wdata;
    bus.mem_write_enable = bus.cpu_mem_write & ~bus.cpu_fault;
    bus.cpu_stall        = 1'b0;
    bus.ext_gnt          = 1'b0;
    bus.ext_fault        = 1'b0;
    case (state)
      ST_CPU: begin
        if (bus.ext_req && (!cpu_active || wait_sat)) state_nxt = ST_EXT_ACC;
      end
      ST_EXT_ACC: begin
        bus.mem_byte_address = bus.ext_addr[ADDR_W-1:0];
        bus.mem_write_data   = bus.ext_wdata;
        bus.mem_write_enable = bus.ext_we & ~ext_bad;
        bus.ext_gnt          = 1'b1;
        bus.ext_fault        = ext_bad;
        bus.cpu_stall        = cpu_active;
        state_nxt            = bus.ext_we ? ST_CPU : ST_EXT_RESP;
      end
      ST_EXT_RESP: begin
        // Read data for EXT arrives this cycle; keep the port quiet.
        bus.mem_write_enable = 1'b0;
        bus.cpu_stall        = cpu_active;
        state_nxt            = ST_CPU;
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  assign cnt_clr = (state == ST_CPU) & (~bus.ext_req | (state_nxt == ST_EXT_ACC));
  assign cnt_inc = (state == ST_CPU) & bus.ext_req & cpu_active;

  dmem_starve_counter #(.MAX_WAIT(MAX_WAIT), .CW(CW)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (wait_cnt),
    .sat   (wait_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CPU;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_EXT_ACC) fault_q <= ext_bad;
    end
  end

  // A faulted EXT read still handshakes but returns zero, never stale memory.
  assign bus.ext_rvalid = (state == ST_EXT_RESP);
  assign bus.ext_rdata  = (state == ST_EXT_RESP && !fault_q) ? bus.mem_read_data : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (CPU port) and an external loader/debug port (EXT port, e.g. UART program/data loader).
- The CPU has priority. EXT is served in idle CPU cycles, or forcibly after a bounded wait by stalling the CPU.
- Performs the address range check on both ports and blocks out-of-range writes.
- Sits between the memory stage and data_memory. Byte truncation and alignment stay upstream in the memory stage.

Parameters:
ADDR_W, 10, memory byte-address width driven to data_memory
ADDR_LIMIT, 1023, highest legal byte address; anything above is a fault
MAX_WAIT, 8, cycles EXT may wait while the CPU is busy before the CPU is forced to stall (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_mem_read  in  1  CPU load this cycle
cpu_mem_write  in  1  CPU store this cycle
cpu_addr  in  32  CPU byte address (ALU result)
cpu_wdata  in  32  CPU store word (already lane-shifted)
cpu_rdata  out  32  memory read data to CPU
cpu_stall  out  1  CPU access not performed this cycle; hold and retry
cpu_fault  out  1  CPU address > ADDR_LIMIT
ext_req  in  1  EXT request; held with addr/data/we stable until ext_gnt
ext_we  in  1  EXT write (1) / read (0)
ext_addr  in  32  EXT byte address
ext_wdata  in  32  EXT write word
ext_gnt  out  1  one-cycle pulse: EXT access performed this cycle
ext_rvalid  out  1  one-cycle pulse: ext_rdata valid
ext_rdata  out  32  EXT read data
ext_fault  out  1  valid with ext_gnt: EXT address was out of range
mem_byte_address  out  ADDR_W  to data_memory
mem_write_enable  out  1  to data_memory
mem_write_data  out  32  to data_memory
mem_read_data  in  32  from data_memory; registered, valid one cycle after the address

Behaviour:
- cpu_active = cpu_mem_read | cpu_mem_write.
- FSM states: S_CPU, S_EXT_ACC, S_EXT_RESP. Reset enters S_CPU.
- Reset values: wait_cnt=0, ext_rvalid=0, ext_rdata=0. Combinational outputs take their S_CPU values with all inputs low. Reset asserted mid-access aborts the access; no EXT grant or response is replayed.
- S_CPU:
  - Memory port is driven from cpu_addr[ADDR_W-1:0] and cpu_wdata.
  - mem_write_enable = cpu_mem_write & ~cpu_fault.
  - cpu_stall = 0.
  - Next state is S_EXT_ACC if ext_req & (~cpu_active | wait_cnt==MAX_WAIT); otherwise stay in S_CPU.
  - The current CPU access always completes.
- S_EXT_ACC:
  - Memory port is driven from ext_addr and ext_wdata.
  - mem_write_enable = ext_we & ~ext_fault.
  - ext_gnt = 1; cpu_stall = cpu_active.
  - Next state is S_EXT_RESP if ~ext_we, otherwise S_CPU.
- S_EXT_RESP:
  - ext_rvalid = 1; ext_rdata = mem_read_data, or 0 if the granted address faulted (fault registered at grant).
  - mem_write_enable = 0; cpu_stall = cpu_active.
  - Next state is S_CPU.
- cpu_rdata = mem_read_data, passed through. The pipeline consumes it one cycle after an unstalled read.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in S_CPU while ext_req & cpu_active.
  - Clears in S_CPU when ext_req=0, and on every transition into S_EXT_ACC.
  - Worst-case EXT latency is MAX_WAIT+1 cycles from ext_req to ext_gnt.
- Faults:
  - cpu_fault = cpu_active & (cpu_addr > ADDR_LIMIT), combinational, 32-bit unsigned compare. It is reported even when cpu_stall=1.
  - ext_fault = ext_gnt & (ext_addr > ADDR_LIMIT).
  - A faulting write never reaches memory. A faulting EXT read still completes the handshake with data 0.
- Simultaneous events:
  - cpu_mem_read & cpu_mem_write both high is treated as a write.
  - ext_req dropped before ext_gnt is illegal; behaviour is undefined and the assertion is flagged in the bench.
- No back-to-back EXT grants: S_CPU always lasts at least one cycle between EXT accesses.

Decomposition:
- Shared package: dmem_arb_state_t enum (S_CPU, S_EXT_ACC, S_EXT_RESP) and a default ADDR_LIMIT constant, reusable by the memory stage exception logic.
- One sub-module is natural: dmem_starve_counter (saturating wait_cnt with clear/increment, parameterised by MAX_WAIT).
- FSM and port mux stay in the top.

Test Plan:
- CPU only: write 0xDEADBEEF @0x010, then read @0x010 -> mem_write_enable=1 for one cycle, cpu_rdata=0xDEADBEEF the next cycle, cpu_stall=0 throughout.
- EXT while CPU idle: ext_req, ext_we=1, addr 0x020, data 0x12345678 -> ext_gnt the next cycle. Then EXT read @0x020 -> ext_gnt, then ext_rvalid with 0x12345678.
- Starvation, MAX_WAIT=8: CPU reads every cycle while ext_req is held -> ext_gnt exactly 9 cycles after ext_req, cpu_stall=1 for 1 cycle (write) or 2 cycles (read), wait_cnt=0 after grant.
- Range check: CPU write to 0x400 -> cpu_fault=1, no memory write (read back @0x000 unchanged). EXT read @0x1000 -> ext_fault=1 at grant, ext_rvalid with ext_rdata=0.
- Reset mid-EXT-read: reset asserted in S_EXT_ACC -> immediately S_CPU, ext_rvalid never pulses, all counters 0; post-reset CPU access works.
- Mixed random traffic against a reference memory model -> no lost or duplicated writes, every EXT request receives exactly one ext_gnt.
